// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: state encoding, default limits
// and the per-state registered flag set.
package program_loader_pkg;

    localparam int unsigned   DW_DEF        = 16;
    localparam int unsigned   AW_DEF        = 16;
    localparam int unsigned   MAXMEMORY_DEF = 4095;
    localparam logic [15:0]   HALT_WORD_DEF = 16'h0FFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } state_t;

    typedef struct packed {
        logic cpu_reset;
        logic in_ready;
        logic busy;
        logic done;
        logic err;
    } flags_t;

    // Status outputs are registered alongside the state, so they are derived
    // from the state being entered rather than the current one.
    function automatic flags_t state_flags(input state_t s);
        flags_t f;
        f           = '0;
        f.cpu_reset = (s != RUN);
        f.in_ready  = (s == LOAD);
        f.busy      = (s == LOAD) || (s == FLUSH);
        f.done      = (s == RUN);
        f.err       = (s == ERROR);
        return f;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Streams a program into instruction memory from address 0, holds the CPU in
// reset until the load completes, then hands the memory address to the PC.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned     DW        = DW_DEF,
    parameter int unsigned     AW        = AW_DEF,
    parameter int unsigned     MAXMEMORY = MAXMEMORY_DEF,
    parameter logic [DW-1:0]   HALT_WORD = HALT_WORD_DEF,
    parameter logic            AUTO_HALT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    input  logic [AW-1:0] pc_addr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] word_count
);

    state_t        state;
    flags_t        fl;
    logic [AW-1:0] ptr;
    logic [AW-1:0] wr_addr;
    logic          accept;
    logic          load_end;
    logic          at_limit;

    assign accept   = in_valid && fl.in_ready;
    assign load_end = in_last || (AUTO_HALT && (in_data == HALT_WORD));
    assign at_limit = (ptr == AW'(MAXMEMORY));

    assign in_ready  = fl.in_ready;
    assign cpu_reset = fl.cpu_reset;
    assign busy      = fl.busy;
    assign done      = fl.done;
    assign err       = fl.err;

    assign mem_addr = (state == RUN) ? pc_addr : wr_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fl         <= state_flags(IDLE);
            ptr        <= '0;
            word_count <= '0;
            wr_addr    <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        fl         <= state_flags(LOAD);
                        ptr        <= '0;
                        word_count <= '0;
                    end
                end
                LOAD: begin
                    // start wins over a word handshaken in the same cycle
                    if (start) begin
                        ptr        <= '0;
                        word_count <= '0;
                    end else if (accept) begin
                        wr_addr    <= ptr;
                        mem_wdata  <= in_data;
                        mem_we     <= 1'b1;
                        word_count <= word_count + 1'b1;
                        if (load_end) begin
                            state <= FLUSH;
                            fl    <= state_flags(FLUSH);
                        end else if (at_limit) begin
                            state <= ERROR;
                            fl    <= state_flags(ERROR);
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state <= RUN;
                    fl    <= state_flags(RUN);
                end
                RUN, ERROR: begin
                    if (start) begin
                        state      <= LOAD;
                        fl         <= state_flags(LOAD);
                        ptr        <= '0;
                        word_count <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    fl    <= state_flags(IDLE);
                end
            endcase
        end
    end

endmodule
